id_issue_scoreboard: RTL and testbench

Issue controller for the decode stage, sitting between decode and the register file.
- Tracks pending destination registers in a 32-entry scoreboard.
- Stalls decode on RAW/WAW hazards and on a full multicycle (MDU) queue.
- Arbitrates the single register-file write port between the ALU writeback path and the MDU.
- Drives the register file's regWriteF / writeReg / writeData inputs directly.

---
 rtl/id_issue_scoreboard_pkg.sv | 11 +
 rtl/id_issue_scoreboard_wb_port_arbiter.sv | 65 ++++++
 rtl/id_issue_scoreboard.sv | 110 +++++++++++
 tb/tb_id_issue_scoreboard.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_scoreboard_pkg.sv
// Shared widths and constants for the decode-stage issue scoreboard and its
// register-file write port arbiter.
package id_issue_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/id_issue_scoreboard_wb_port_arbiter.sv
// Register-file write port arbiter: fixed ALU priority over the MDU, with a
// saturating counter of the cycles that a pending MDU write has lost arbitration.
module wb_port_arbiter
    import id_issue_scoreboard_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  aluWbValid,
    input  logic [REG_ADDR_W-1:0] aluWbReg,
    input  logic [DATA_W-1:0]     aluWbData,
    input  logic                  mduWbValid,
    input  logic [REG_ADDR_W-1:0] mduWbReg,
    input  logic [DATA_W-1:0]     mduWbData,
    output logic                  wrEn,
    output logic [REG_ADDR_W-1:0] wrReg,
    output logic [DATA_W-1:0]     wrData,
    output logic                  mduGrant,
    output logic                  starve
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starveCnt_q;
    logic [7:0] starveCnt_d;

    // Gated by resetN so that nothing is written while reset is held.
    always_comb begin
        wrEn     = 1'b0;
        wrReg    = REG_ZERO;
        wrData   = '0;
        mduGrant = 1'b0;
        if (resetN && aluWbValid) begin
            wrEn   = 1'b1;
            wrReg  = aluWbReg;
            wrData = aluWbData;
        end else if (resetN && mduWbValid) begin
            wrEn     = 1'b1;
            wrReg    = mduWbReg;
            wrData   = mduWbData;
            mduGrant = 1'b1;
        end
    end

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!mduWbValid || mduGrant) begin
            starveCnt_d = '0;
        end else if (aluWbValid && starveCnt_q != LIMIT) begin
            starveCnt_d = starveCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

    assign starve = (starveCnt_q == LIMIT);

endmodule

// File: rtl/id_issue_scoreboard.sv
// Decode-stage issue controller: pending-destination scoreboard, RAW/WAW and
// MDU-occupancy stalls, and the single register-file write port.
module id_issue_scoreboard
    import id_issue_scoreboard_pkg::*;
#(
    parameter int MDU_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  issueValid,
    input  logic [REG_ADDR_W-1:0] srcA,
    input  logic [REG_ADDR_W-1:0] srcB,
    input  logic                  usesB,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  destValid,
    input  logic                  isLong,
    output logic                  issueStall,
    input  logic                  aluWbValid,
    input  logic [REG_ADDR_W-1:0] aluWbReg,
    input  logic [DATA_W-1:0]     aluWbData,
    input  logic                  mduWbValid,
    input  logic [REG_ADDR_W-1:0] mduWbReg,
    input  logic [DATA_W-1:0]     mduWbData,
    output logic                  mduWbReady,
    output logic                  regWriteF,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic [NUM_REGS-1:0]   busyVec
);

    localparam int              MDU_W    = $clog2(MDU_DEPTH + 1);
    localparam logic [MDU_W-1:0] MDU_FULL = MDU_W'(MDU_DEPTH);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [MDU_W-1:0]    mduOut_q, mduOut_d;
    logic                starve;
    logic                mduGrant;
    logic                hazard;
    logic                accept;

    wb_port_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) uArbiter (
        .clock      (clock),
        .resetN     (resetN),
        .aluWbValid (aluWbValid),
        .aluWbReg   (aluWbReg),
        .aluWbData  (aluWbData),
        .mduWbValid (mduWbValid),
        .mduWbReg   (mduWbReg),
        .mduWbData  (mduWbData),
        .wrEn       (regWriteF),
        .wrReg      (writeReg),
        .wrData     (writeData),
        .mduGrant   (mduGrant),
        .starve     (starve)
    );

    // Stall sees only registered state, so a same-cycle writeback never lifts it.
    assign hazard = busy_q[srcA]
                  | (usesB && busy_q[srcB])
                  | (destValid && busy_q[dest])
                  | (isLong && mduOut_q == MDU_FULL)
                  | starve;

    assign issueStall = !resetN || (issueValid && hazard);
    assign accept     = resetN && issueValid && !hazard;
    assign mduWbReady = mduGrant;
    assign busyVec    = busy_q;

    // Set is applied after clear so an accept wins over a same-cycle write.
    always_comb begin
        busy_d = busy_q;
        if (regWriteF) begin
            busy_d[writeReg] = 1'b0;
        end
        if (accept && destValid && dest != REG_ZERO) begin
            busy_d[dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        mduOut_d = mduOut_q;
        if (accept && isLong && !(mduGrant && mduOut_q != '0)) begin
            mduOut_d = mduOut_q + 1'b1;
        end else if (!(accept && isLong) && mduGrant && mduOut_q != '0) begin
            mduOut_d = mduOut_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            busy_q   <= '0;
            mduOut_q <= '0;
        end else begin
            busy_q   <= busy_d;
            mduOut_q <= mduOut_d;
        end
    end

    // An MDU result with nothing outstanding means the MDU broke protocol.
    always @(posedge clock) begin
        if (resetN && mduGrant) begin
            assert (mduOut_q != '0);
        end
    end

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Directed bench for id_issue_scoreboard: a vector table for the single-cycle
// behaviour plus hand sequences for MDU occupancy, starvation and reset.
module tb_id_issue_scoreboard;

    typedef struct packed {
        logic        iv;
        logic [4:0]  srcA;
        logic [4:0]  srcB;
        logic        usesB;
        logic [4:0]  dest;
        logic        dv;
        logic        isLong;
        logic        aluV;
        logic [4:0]  aluReg;
        logic [31:0] aluData;
        logic        mduV;
        logic [4:0]  mduReg;
        logic [31:0] mduData;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        stall;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        ready;
        logic [31:0] busy;
    } vec_t;

    logic        clock;
    logic        resetN;
    logic        issueValid;
    logic [4:0]  srcA;
    logic [4:0]  srcB;
    logic        usesB;
    logic [4:0]  dest;
    logic        destValid;
    logic        isLong;
    logic        issueStall;
    logic        aluWbValid;
    logic [4:0]  aluWbReg;
    logic [31:0] aluWbData;
    logic        mduWbValid;
    logic [4:0]  mduWbReg;
    logic [31:0] mduWbData;
    logic        mduWbReady;
    logic        regWriteF;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] busyVec;

    int total = 0;
    int bad   = 0;

    localparam int NVEC = 15;
    vec_t  tbl [NVEC];
    stim_t idle;

    id_issue_scoreboard #(
        .MDU_DEPTH   (4),
        .STARVE_LIMIT(8)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .issueValid (issueValid),
        .srcA       (srcA),
        .srcB       (srcB),
        .usesB      (usesB),
        .dest       (dest),
        .destValid  (destValid),
        .isLong     (isLong),
        .issueStall (issueStall),
        .aluWbValid (aluWbValid),
        .aluWbReg   (aluWbReg),
        .aluWbData  (aluWbData),
        .mduWbValid (mduWbValid),
        .mduWbReg   (mduWbReg),
        .mduWbData  (mduWbData),
        .mduWbReady (mduWbReady),
        .regWriteF  (regWriteF),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .busyVec    (busyVec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic stim_t mk(logic iv, logic [4:0] a, logic [4:0] b, logic ub,
                                 logic [4:0] d, logic dv, logic lg,
                                 logic av, logic [4:0] ar, logic [31:0] ad,
                                 logic mv, logic [4:0] mr, logic [31:0] md);
        stim_t s;
        s.iv = iv; s.srcA = a; s.srcB = b; s.usesB = ub;
        s.dest = d; s.dv = dv; s.isLong = lg;
        s.aluV = av; s.aluReg = ar; s.aluData = ad;
        s.mduV = mv; s.mduReg = mr; s.mduData = md;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        issueValid = s.iv;
        srcA       = s.srcA;
        srcB       = s.srcB;
        usesB      = s.usesB;
        dest       = s.dest;
        destValid  = s.dv;
        isLong     = s.isLong;
        aluWbValid = s.aluV;
        aluWbReg   = s.aluReg;
        aluWbData  = s.aluData;
        mduWbValid = s.mduV;
        mduWbReg   = s.mduReg;
        mduWbData  = s.mduData;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check stall after settling.
    task automatic stepStall(input string name, input stim_t s, input logic expStall);
        @(negedge clock);
        applyStimulus(s);
        #1;
        checkOutput(name, 32'(issueStall), 32'(expStall));
    endtask

    initial begin
        idle = mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        tbl[0]  = '{idle, 0, 0, 5'd0, 32'h0, 0, 32'h0};
        tbl[1]  = '{mk(1, 5'd1, 5'd2, 1, 5'd8, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0),
                    0, 0, 5'd0, 32'h0, 0, 32'h0};
        tbl[2]  = '{mk(1, 5'd8, 5'd0, 0, 5'd10, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0),
                    1, 0, 5'd0, 32'h0, 0, 32'h100};
        tbl[3]  = '{mk(1, 5'd8, 5'd0, 0, 5'd10, 1, 0, 1, 5'd8, 32'hAAAA, 0, 5'd0, 32'h0),
                    1, 1, 5'd8, 32'hAAAA, 0, 32'h100};
        tbl[4]  = '{mk(1, 5'd8, 5'd0, 0, 5'd10, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0),
                    0, 0, 5'd0, 32'h0, 0, 32'h0};
        tbl[5]  = '{mk(1, 5'd0, 5'd0, 0, 5'd9, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0),
                    0, 0, 5'd0, 32'h0, 0, 32'h400};
        tbl[6]  = '{mk(1, 5'd0, 5'd0, 0, 5'd9, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0),
                    1, 0, 5'd0, 32'h0, 0, 32'h600};
        tbl[7]  = '{mk(1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0),
                    0, 0, 5'd0, 32'h0, 0, 32'h600};
        tbl[8]  = '{mk(1, 5'd0, 5'd10, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0),
                    0, 0, 5'd0, 32'h0, 0, 32'h600};
        tbl[9]  = '{mk(1, 5'd0, 5'd10, 1, 5'd0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0),
                    1, 0, 5'd0, 32'h0, 0, 32'h600};
        tbl[10] = '{mk(1, 5'd0, 5'd0, 0, 5'd5, 1, 1, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0),
                    0, 1, 5'd9, 32'h99, 0, 32'h600};
        tbl[11] = '{mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd10, 32'h10, 0, 5'd0, 32'h0),
                    0, 1, 5'd10, 32'h10, 0, 32'h420};
        tbl[12] = '{mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd3, 32'h11, 1, 5'd5, 32'h22),
                    0, 1, 5'd3, 32'h11, 0, 32'h20};
        tbl[13] = '{mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd5, 32'h22),
                    0, 1, 5'd5, 32'h22, 1, 32'h20};
        tbl[14] = '{idle, 0, 0, 5'd0, 32'h0, 0, 32'h0};

        // Reset state, with write requests pending to prove they are gated.
        resetN = 1'b0;
        applyStimulus(mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66));
        #12;
        checkOutput("reset_stall", 32'(issueStall), 32'h1);
        checkOutput("reset_wen", 32'(regWriteF), 32'h0);
        checkOutput("reset_ready", 32'(mduWbReady), 32'h0);
        checkOutput("reset_busy", busyVec, 32'h0);
        @(negedge clock);
        applyStimulus(idle);
        #2 resetN = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            applyStimulus(tbl[i].s);
            #1;
            checkOutput($sformatf("vec%0d_stall", i), 32'(issueStall), 32'(tbl[i].stall));
            checkOutput($sformatf("vec%0d_wen", i), 32'(regWriteF), 32'(tbl[i].wen));
            if (tbl[i].wen) begin
                checkOutput($sformatf("vec%0d_wreg", i), 32'(writeReg), 32'(tbl[i].wreg));
                checkOutput($sformatf("vec%0d_wdata", i), writeData, tbl[i].wdata);
            end
            checkOutput($sformatf("vec%0d_ready", i), 32'(mduWbReady), 32'(tbl[i].ready));
            checkOutput($sformatf("vec%0d_busy", i), busyVec, tbl[i].busy);
        end

        // MDU occupancy: four long ops fill the queue, the fifth waits for a grant.
        for (int i = 0; i < 4; i++) begin
            stepStall($sformatf("mdu_fill%0d", i),
                      mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        end
        stepStall("mdu_full_long",
                  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b1);
        stepStall("mdu_full_short",
                  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        stepStall("mdu_full_grant",
                  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 32'h0, 1, 5'd0, 32'h5), 1'b1);
        checkOutput("mdu_full_ready", 32'(mduWbReady), 32'h1);
        stepStall("mdu_after_grant",
                  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepStall($sformatf("mdu_drain%0d", i),
                      mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h7), 1'b0);
            checkOutput($sformatf("mdu_drain%0d_ready", i), 32'(mduWbReady), 32'h1);
        end

        // Starvation: one long op outstanding, ALU never idle for ten cycles.
        stepStall("starve_setup",
                  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        for (int k = 0; k < 10; k++) begin
            stepStall($sformatf("starve_cyc%0d", k),
                      mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd1, 32'(k), 1, 5'd2, 32'h2222),
                      (k >= 8));
            checkOutput($sformatf("starve_cyc%0d_ready", k), 32'(mduWbReady), 32'h0);
        end
        stepStall("starve_drain",
                  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd2, 32'h2222), 1'b1);
        checkOutput("starve_drain_ready", 32'(mduWbReady), 32'h1);
        checkOutput("starve_drain_wreg", 32'(writeReg), 32'h2);
        stepStall("starve_cleared",
                  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);

        // Mid-run reset with two busy registers and two long ops outstanding.
        stepStall("rst_setup8",
                  mk(1, 5'd0, 5'd0, 0, 5'd8, 1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        stepStall("rst_setup9",
                  mk(1, 5'd0, 5'd0, 0, 5'd9, 1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        @(negedge clock);
        applyStimulus(idle);
        #1;
        checkOutput("rst_pre_busy", busyVec, 32'h300);
        applyStimulus(mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66));
        resetN = 1'b0;
        #1;
        checkOutput("rst_mid_busy", busyVec, 32'h0);
        checkOutput("rst_mid_wen", 32'(regWriteF), 32'h0);
        checkOutput("rst_mid_ready", 32'(mduWbReady), 32'h0);
        checkOutput("rst_mid_stall", 32'(issueStall), 32'h1);
        @(negedge clock);
        applyStimulus(idle);
        #2 resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepStall($sformatf("rst_post_long%0d", i),
                      mk(1, 5'd8, 5'd9, 1, 5'd0, 0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b0);
        end
        stepStall("rst_post_full",
                  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0), 1'b1);

        @(negedge clock);
        applyStimulus(idle);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
